// File: rtl/cla_slice_adder.sv
// cla_slice_adder: multi-cycle WIDTH-bit adder that processes one 4-bit slice per clock,
// least significant slice first. Each slice uses a flattened 4-bit carry-lookahead
// generator. The slice carry-out is registered and becomes the next slice's carry-in.
// Valid/ready handshakes on both the operand side and the result side.
module cla_slice_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0] a_sl;
    logic [3:0] b_sl;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] s_sl;
    logic       last_slice;

    // Slice select, propagate/generate, and flattened lookahead carries for the current slice.
    always_comb begin
        a_sl = a_q[{idx_q, 2'b00} +: 4];
        b_sl = b_q[{idx_q, 2'b00} +: 4];
        p    = a_sl ^ b_sl;
        g    = a_sl & b_sl;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s_sl = p ^ c[3:0];
        last_slice = (idx_q == IW'(NSLICE - 1));
    end

    // Control FSM plus operand latch, per-slice sum write and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= s_sl;
                    carry_q <= c[4];
                    idx_q   <= idx_q + IW'(1);
                    if (last_slice) begin
                        cout_q  <= c[4];
                        ovf_q   <= c[3] ^ c[4];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result stays on the outputs after the handshake; only valid drops.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode directly from state; no accept while DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_cla_slice_adder.sv
// Bench for cla_slice_adder (WIDTH=16): directed vector table, random operands against an
// arithmetic reference, backpressure holds, and an asynchronous reset mid-operation.
module tb_cla_slice_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_bad = 0;

    cla_slice_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // One full transaction: accept, scramble inputs during RUN, check latency, result,
    // backpressure stability for 'hold' cycles, then handshake.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec,
                          input logic eo, input int hold);
        int lat;
        logic [W-1:0] s_seen;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            a = W'($urandom); b = W'($urandom);
        end
        check({name, ".latency"}, 32'(lat), 32'd4);
        check({name, ".sum"}, 32'(sum), 32'(es));
        check({name, ".cout"}, 32'(cout), 32'(ec));
        check({name, ".ovf"}, 32'(ovf), 32'(eo));
        s_seen = sum;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({name, ".hold_sum"}, 32'(sum), 32'(s_seen));
            check({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".post_valid"}, 32'(out_valid), 32'd0);
        check({name, ".post_in_ready"}, 32'(in_ready), 32'd1);
        check({name, ".post_sum"}, 32'(sum), 32'(es));
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] rs;
        logic rc, ro;
        logic [W-1:0] ra, rb;
        logic rci;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0, ovf: 1'b0, hold: 3};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0, hold: 0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1, hold: 1};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1, hold: 0};
        vecs[4] = '{a: 16'h0000, b: 16'h0000, cin: 1'b1, sum: 16'h0001, cout: 1'b0, ovf: 1'b0, hold: 0};
        vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, ovf: 1'b0, hold: 2};
        vecs[6] = '{a: 16'h8000, b: 16'hFFFF, cin: 1'b0, sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, hold: 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
        #12;
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Inputs with in_valid low must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("idle.in_ready", 32'(in_ready), 32'd1);
        check("idle.out_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].hold);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;  // long propagate chains
            model(ra, rb, rci, rs, rc, ro);
            run_op($sformatf("rand%0d", i), ra, rb, rci, rs, rc, ro, int'($urandom_range(0, 2)));
        end

        // Reset while RUN is processing slice 2.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset.out_valid", 32'(out_valid), 32'd0);
        check("midrun_reset.sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrun_reset.in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("midrun_reset.no_valid", 32'(out_valid), 32'd0);
        run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
